// File: rtl/tns_pkg.sv
// Shared constants and types for the 33-TSV TNS receive path.
package tns_pkg;
    localparam int BLEN11 = 30;
    localparam int N_GRP  = 11;
    localparam int TSV_W  = 33;
    localparam logic [BLEN11:0] TNS_MAX = 31'd847425747;

    typedef logic [TSV_W-1:0] tns_word_t;

    typedef struct packed {
        logic              err;
        logic [BLEN11-1:0] data;
    } rx_entry_t;
endpackage

// File: rtl/TNS_dec_33.sv
// TNS decoder: each 3-bit group is one base-7 digit, codes 3'b011 and 3'b100
// both carry digit 3 (the encoder picks whichever the reference bit allows).
module TNS_dec_33 (
    input  logic [32:0] tsv_word,
    output logic [30:0] dec_value
);
    logic [2:0] g;
    logic [2:0] d;

    always_comb begin
        dec_value = '0;
        g         = '0;
        d         = '0;
        for (int j = 10; j >= 0; j--) begin
            g = tsv_word[3*j +: 3];
            d = (g < 3'd4) ? g : g - 3'd1;
            dec_value = dec_value * 31'd7 + {28'd0, d};
        end
    end
endmodule

// File: rtl/tns_rx_fifo.sv
// Small synchronous FIFO of decoded entries; a pop on a full FIFO frees the
// slot for a same-cycle push.
module tns_rx_fifo
    import tns_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  rx_entry_t wdata,
    output rx_entry_t rdata,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    rx_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/tns_rx_33.sv
// Receive stage for the 33-TSV TNS link: capture, pattern/range check,
// decode, buffer and hand off with sticky flags and saturating counters.
module tns_rx_33
    import tns_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TSV_W-1:0]  tsv_in,
    input  logic              tsv_valid,
    output logic [BLEN11-1:0] data_out,
    output logic              data_err,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [N_GRP-1:0]  err_group,
    output logic              err_range,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  ovf_count
);
    tns_word_t        s1_word;
    logic             s1_vld;
    logic [N_GRP-1:0] s1_prev;
    logic [N_GRP-1:0] prev_r;

    logic [BLEN11:0]  dec_value;
    logic [N_GRP-1:0] grp_err;
    logic             rng_err;
    logic             word_err;
    logic [2:0]       g;

    rx_entry_t        wr_entry;
    rx_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_word <= '0;
            s1_vld  <= 1'b0;
            s1_prev <= '0;
            prev_r  <= '0;
        end else begin
            s1_vld <= tsv_valid;
            if (tsv_valid) begin
                s1_word <= tsv_in;
                s1_prev <= prev_r;
                for (int j = 0; j < N_GRP; j++) prev_r[j] <= tsv_in[3*j+2];
            end
        end
    end

    TNS_dec_33 u_dec (
        .tsv_word  (s1_word),
        .dec_value (dec_value)
    );

    // g is {ref, bit1, bit0}: 3'b100 needs ref previously 1, 3'b011 needs it 0
    always_comb begin
        grp_err = '0;
        g       = '0;
        for (int j = 0; j < N_GRP; j++) begin
            g = s1_word[3*j +: 3];
            grp_err[j] = ((g == 3'b100) && !s1_prev[j]) || ((g == 3'b011) && s1_prev[j]);
        end
    end

    assign rng_err       = (dec_value > TNS_MAX);
    assign word_err      = (|grp_err) || rng_err;
    assign wr_entry.err  = word_err;
    assign wr_entry.data = dec_value[BLEN11-1:0];

    assign pop  = data_valid && data_ready;
    assign drop = s1_vld && fifo_full && !pop;

    tns_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (s1_vld),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data_valid = !fifo_empty;
    assign data_out   = head.data;
    assign data_err   = head.err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_group <= '0;
            err_range <= 1'b0;
            err_count <= '0;
            ovf_count <= '0;
        end else if (s1_vld) begin
            err_group <= err_group | grp_err;
            err_range <= err_range | rng_err;
            if (word_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            if (drop && (ovf_count != '1)) ovf_count <= ovf_count + CNT_W'(1);
        end
    end
endmodule
